// File: rtl/note_tone_i2s_pkg.sv
// note_tone_pkg: shared note constants, frame geometry and types for the tone-to-I2S back end
package note_tone_pkg;
  localparam int DIV_W = 22;
  localparam int SAMPLE_W = 16;
  localparam int SLOT_W = 16;
  localparam int FRAME_LEN = 512;
  localparam int FCNT_W = $clog2(FRAME_LEN);
  localparam int SLOT_B = $clog2(SLOT_W);
  typedef logic [DIV_W-1:0] div_t;
  typedef logic [SAMPLE_W-1:0] sample_t;
  localparam div_t NOTE_DO = 22'd191571;
  localparam div_t NOTE_RE = 22'd170648;
  localparam div_t NOTE_MI = 22'd151515;
  localparam div_t NOTE_FA = 22'd143266;
  localparam div_t NOTE_SO = 22'd127551;
  localparam div_t NOTE_LA = 22'd113636;
  localparam div_t NOTE_SILENCE = 22'd0;
endpackage

// File: rtl/note_tone_i2s_if.sv
// note_tone_i2s_if: sequencer note input, mute, piezo tone and four-wire I2S DAC pins
interface note_tone_i2s_if;
  import note_tone_pkg::*;
  div_t note_div;
  logic mute;
  logic buzz;
  logic mclk;
  logic lrck;
  logic sck;
  logic sdin;
  modport master (output note_div, mute, input buzz, mclk, lrck, sck, sdin);
  modport slave (input note_div, mute, output buzz, mclk, lrck, sck, sdin);
endinterface

// File: rtl/note_tone_i2s_i2s_tx.sv
// i2s_tx: 512-cycle I2S frame counter, DAC clocks and one-bit-delayed MSB-first serializer of a mono sample
module i2s_tx
  import note_tone_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  sample_t i_sample,
  output logic    o_load,
  output logic    o_mclk,
  output logic    o_sck,
  output logic    o_lrck,
  output logic    o_sdin
);
  logic [FCNT_W-1:0] r_fcnt;
  logic [2*SAMPLE_W-1:0] r_frame;
  logic r_sdin;
  logic [FCNT_W-SLOT_B-1:0] w_slot;
  assign w_slot = r_fcnt[FCNT_W-1:SLOT_B];
  assign o_load = r_fcnt == FCNT_W'(SLOT_W - 1);
  assign o_mclk = r_fcnt[1];
  assign o_sck = r_fcnt[SLOT_B-1];
  assign o_lrck = r_fcnt[FCNT_W-1];
  assign o_sdin = r_sdin;
  // the bit for the next slot n sits at frame[-n mod 32], which is ~slot of the current one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fcnt <= '0;
      r_frame <= '0;
      r_sdin <= 1'b0;
    end else begin
      r_fcnt <= r_fcnt + FCNT_W'(1);
      if (o_load) r_frame <= {i_sample, i_sample};
      if (&r_fcnt[SLOT_B-1:0]) r_sdin <= o_load ? i_sample[SAMPLE_W-1] : r_frame[~w_slot];
    end
  end
endmodule

// File: rtl/note_tone_i2s.sv
// note_tone_i2s: note_div square tone to piezo and I2S DAC; NOTE_TONE_SYNC_UPDATE_EN defers note changes to the half-period wrap
module note_tone_i2s
  import note_tone_pkg::*;
#(
  parameter sample_t AMP = 16'h2000
) (
  input logic clk,
  input logic rst,
  note_tone_i2s_if.slave bus
);
  div_t r_div_cur;
  div_t r_tcnt;
  logic r_buzz;
  logic w_idle;
  logic w_wrap;
  logic w_toggle;
  logic w_restart;
  logic w_load;
  div_t w_div_nxt;
  sample_t w_sample;
  assign w_idle = r_div_cur == '0;
  assign w_wrap = !w_idle && r_tcnt == r_div_cur - DIV_W'(1);
`ifdef NOTE_TONE_SYNC_UPDATE_EN
  assign w_toggle = w_wrap;
  assign w_restart = w_wrap || w_idle;
  assign w_div_nxt = w_restart ? bus.note_div : r_div_cur;
`else
  // a new note restarts the half period but keeps the current level
  assign w_toggle = w_wrap && bus.note_div == r_div_cur;
  assign w_restart = w_wrap || w_idle || bus.note_div != r_div_cur;
  assign w_div_nxt = bus.note_div;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cur <= '0;
      r_tcnt <= '0;
      r_buzz <= 1'b0;
    end else begin
      r_div_cur <= w_div_nxt;
      r_tcnt <= w_restart ? '0 : r_tcnt + DIV_W'(1);
      r_buzz <= !w_idle && (r_buzz ^ w_toggle);
    end
  end
  assign w_sample = (!w_load || bus.mute || w_idle) ? '0 : r_buzz ? AMP : sample_t'(-AMP);
  assign bus.buzz = r_buzz;
  i2s_tx u_tx (
    .clk      (clk),
    .rst      (rst),
    .i_sample (w_sample),
    .o_load   (w_load),
    .o_mclk   (bus.mclk),
    .o_sck    (bus.sck),
    .o_lrck   (bus.lrck),
    .o_sdin   (bus.sdin)
  );
endmodule
